// File: rtl/game_pkg.sv
// Shared game constants: screen size, colours, ship sprite bitmap and drawer states.
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    // Index 0 is the top row; within a byte the MSB is the leftmost column.
    localparam logic [0:7][7:0] SHIP_SPRITE = {
        8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW
    } draw_state_t;

endpackage

// File: rtl/ship_sprite_rom.sv
// Combinational lookup of one ship sprite bit by row and column.
module ship_sprite_rom
    import game_pkg::*;
(
    input  logic [2:0] r,
    input  logic [2:0] c,
    output logic       pix_bit
);

    assign pix_bit = SHIP_SPRITE[r][3'd7 - c];

endmodule

// File: rtl/ship_sprite_drawer.sv
// Erases the ship at its old position, then draws it at the new one, one registered pixel per cycle.
// done is registered so it only rises once the last pixel has left the output registers.
module ship_sprite_drawer
    import game_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] oldX,
    input  logic [6:0] oldY,
    input  logic [7:0] newX,
    input  logic [6:0] newY,
    input  logic [2:0] shipColour,
    input  logic       skipErase,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       done
);

    localparam logic [5:0] P_LAST = 6'(SPRITE_W * SPRITE_H - 1);

    draw_state_t state_q, state_d;
    logic [5:0]  p_q, p_d;
    logic [7:0]  old_x_q, old_x_d, new_x_q, new_x_d;
    logic [6:0]  old_y_q, old_y_d, new_y_q, new_y_d;
    logic [2:0]  ship_col_q, ship_col_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        wen_q, wen_d;
    logic        done_q, done_d;

    logic [2:0]  col_idx;
    logic [2:0]  row_idx;
    logic        sprite_bit;

    assign col_idx = p_q[2:0];
    assign row_idx = p_q[5:3];

    ship_sprite_rom u_rom (
        .r       (row_idx),
        .c       (col_idx),
        .pix_bit (sprite_bit)
    );

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        ship_col_d = ship_col_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = BLACK;
        wen_d      = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                p_d    = 6'd0;
                done_d = 1'b1;
                if (start) begin
                    old_x_d    = oldX;
                    old_y_d    = oldY;
                    new_x_d    = newX;
                    new_y_d    = newY;
                    ship_col_d = shipColour;
                    state_d    = skipErase ? ST_DRAW : ST_ERASE;
                    done_d     = 1'b0;
                end
            end
            ST_ERASE: begin
                x_d      = old_x_q + 8'(col_idx);
                y_d      = old_y_q + 7'(row_idx);
                colour_d = BLACK;
                wen_d    = 1'b1;
                p_d      = p_q + 6'd1;
                if (p_q == P_LAST) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                x_d      = new_x_q + 8'(col_idx);
                y_d      = new_y_q + 7'(row_idx);
                colour_d = sprite_bit ? ship_col_q : BLACK;
                wen_d    = 1'b1;
                p_d      = p_q + 6'd1;
                if (p_q == P_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                p_d     = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            p_q        <= 6'd0;
            old_x_q    <= 8'd0;
            old_y_q    <= 7'd0;
            new_x_q    <= 8'd0;
            new_y_q    <= 7'd0;
            ship_col_q <= BLACK;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= BLACK;
            wen_q      <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            new_x_q    <= new_x_d;
            new_y_q    <= new_y_d;
            ship_col_q <= ship_col_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = wen_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ship_sprite_drawer.sv
// Directed bench for ship_sprite_drawer: captures each write pass and checks it against a pixel model.
module tb_ship_sprite_drawer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] oldX;
    logic [6:0] oldY;
    logic [7:0] newX;
    logic [6:0] newY;
    logic [2:0] shipColour;
    logic       skipErase;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] cap [0:255];
    int          n_cap;
    bit          pass_ended;

    logic [7:0] rows [0:7] = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18};

    ship_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .oldX       (oldX),
        .oldY       (oldY),
        .newX       (newX),
        .newY       (newY),
        .shipColour (shipColour),
        .skipErase  (skipErase),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pix(input int px, input int py, input logic [2:0] pc);
        logic [7:0] xx;
        logic [6:0] yy;
        xx = 8'(px % 256);
        yy = 7'(py % 128);
        return {xx, yy, pc};
    endfunction

    // Expected k-th pixel of a pass, {x, y, colour}.
    function automatic logic [17:0] model(input int k, input int ox, input int oy,
                                          input int nx, input int ny,
                                          input logic [2:0] col, input bit skip);
        int kk, p, r, c;
        logic [7:0] row;
        kk = skip ? k + 64 : k;
        p  = kk % 64;
        r  = p / 8;
        c  = p % 8;
        if (kk < 64) return pix(ox + c, oy + r, 3'b000);
        row = rows[r];
        return pix(nx + c, ny + r, row[7 - c] ? col : 3'b000);
    endfunction

    task automatic launch(input int ox, input int oy, input int nx, input int ny,
                          input logic [2:0] col, input bit skip);
        oldX = 8'(ox); oldY = 7'(oy); newX = 8'(nx); newY = 7'(ny);
        shipColour = col; skipErase = skip; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("done_falls", {31'd0, done}, 32'd0);
    endtask

    // Collects the consecutive writeEn run; optional mid-pass start poke or reset.
    task automatic capture(input int poke_at, input int reset_at);
        n_cap = 0;
        pass_ended = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (writeEn) begin
                cap[n_cap] = {x, y, colour};
                n_cap++;
            end else if (n_cap > 0) begin
                pass_ended = 1;
                break;
            end
            if (n_cap == poke_at) begin
                start = 1'b1; newX = 8'd200; newY = 7'd100; oldX = 8'd5; skipErase = 1'b1;
            end
            if (n_cap == poke_at + 1) start = 1'b0;
            if (n_cap == reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                pass_ended = 1;
                break;
            end
            @(negedge clock);
        end
        chk("pass_terminates", {31'd0, pass_ended}, 32'd1);
    endtask

    task automatic check_pass(input string tag, input int len, input int ox, input int oy,
                              input int nx, input int ny, input logic [2:0] col, input bit skip);
        int bad;
        bad = 0;
        chk({tag, "_len"}, n_cap, len);
        chk({tag, "_done_after"}, {30'd0, done, writeEn}, 32'd2);
        chk({tag, "_colour_idle"}, {29'd0, colour}, 32'd0);
        for (int k = 0; k < n_cap && k < len; k++)
            if (cap[k] !== model(k, ox, oy, nx, ny, col, skip)) bad++;
        chk({tag, "_pixels_bad"}, bad, 0);
    endtask

    initial begin
        int ones, popc;
        int wrap_x [0:7] = '{252, 253, 254, 255, 0, 1, 2, 3};
        int wrap_y [0:7] = '{124, 125, 126, 127, 0, 1, 2, 3};

        reset = 1'b1; start = 1'b0; skipErase = 1'b0; shipColour = 3'b000;
        oldX = 8'd0; oldY = 7'd0; newX = 8'd0; newY = 7'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            chk("idle_after_reset", {16'd0, done, writeEn, x, y, 1'b0}, {16'd0, 1'b1, 1'b0, 8'd0, 7'd0, 1'b0});
            @(negedge clock);
        end

        // Full erase + draw, one pixel to the right.
        launch(20, 30, 21, 30, 3'b111, 1'b0);
        capture(-1, -1);
        check_pass("move", 128, 20, 30, 21, 30, 3'b111, 1'b0);
        chk("pix0",  {14'd0, cap[0]},  {14'd0, pix(20, 30, 3'b000)});
        chk("pix63", {14'd0, cap[63]}, {14'd0, pix(27, 37, 3'b000)});
        chk("pix64", {14'd0, cap[64]}, {14'd0, pix(21, 30, 3'b000)});
        chk("pix67", {14'd0, cap[67]}, {14'd0, pix(24, 30, 3'b111)});
        chk("pix88", {14'd0, cap[88]}, {14'd0, pix(21, 33, 3'b111)});
        chk("pix91", {14'd0, cap[91]}, {14'd0, pix(24, 33, 3'b111)});

        // Draw-only pass; lit pixel count must equal the sprite popcount.
        @(negedge clock);
        launch(0, 0, 0, 0, 3'b010, 1'b1);
        capture(-1, -1);
        check_pass("skip", 64, 0, 0, 0, 0, 3'b010, 1'b1);
        ones = 0;
        popc = 0;
        for (int k = 0; k < n_cap; k++) if (cap[k][2:0] == 3'b010) ones++;
        for (int r = 0; r < 8; r++) popc += $countones(rows[r]);
        chk("popcount", ones, popc);
        chk("popcount_const", ones, 40);

        // Coordinate wrap at the right and bottom edges.
        launch(0, 0, 252, 124, 3'b101, 1'b1);
        capture(-1, -1);
        check_pass("wrap", 64, 0, 0, 252, 124, 3'b101, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_x", {24'd0, cap[i][17:10]}, wrap_x[i]);
            chk("wrap_y", {25'd0, cap[i * 8][9:3]}, wrap_y[i]);
        end

        // Start and input changes while busy must not disturb the pass.
        launch(10, 10, 11, 12, 3'b011, 1'b0);
        capture(10, -1);
        check_pass("ignore_start", 128, 10, 10, 11, 12, 3'b011, 1'b0);
        @(negedge clock);
        chk("no_queued_start", {30'd0, done, writeEn}, 32'd2);

        // Reset mid-pass, then a clean full pass.
        launch(40, 40, 41, 40, 3'b111, 1'b0);
        capture(-1, 70);
        chk("rst_mid_len", n_cap, 70);
        chk("rst_mid_outputs", {16'd0, done, writeEn, x, y, 1'b0}, {16'd0, 1'b1, 1'b0, 8'd0, 7'd0, 1'b0});
        chk("rst_mid_colour", {29'd0, colour}, 32'd0);
        launch(40, 40, 41, 40, 3'b111, 1'b0);
        capture(-1, -1);
        check_pass("after_rst", 128, 40, 40, 41, 40, 3'b111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
